// File: rtl/bnn_pkg.sv
// Shared definitions for the activation skew feeder: default geometry and FSM state encoding.
// Purely declarative; no latency or flow control of its own.
package bnn_pkg;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage valid+data shift line; data is forced to zero on entry whenever valid is low.
// Latency DEPTH cycles, advances every cycle with no backpressure.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              vld_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      // Gating here keeps every later stage clean, so the output never carries stale words.
      vld_q[0] <= push_valid;
      dat_q[0] <= push_valid ? push_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid = vld_q[DEPTH-1];
  assign data  = dat_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Skews an accepted activation vector across ROWS array rows: row r sees its element r+1 cycles after accept.
// Upstream is valid/ready (ready drops for ROWS cycles after a tile's last vector); downstream has no backpressure.
module act_skew_feeder
  import bnn_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS-1:0][DATA_W-1:0]  in_data,
  input  logic                         in_last,
  output logic [ROWS-1:0][DATA_W-1:0]  act_out,
  output logic [ROWS-1:0]              act_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int CNT_W = $clog2(ROWS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign in_ready = (state_q != ST_DRAIN);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = in_last ? ST_DRAIN : ST_STREAM;
          cnt_d   = '0;
        end
      end
      ST_STREAM: begin
        busy = 1'b1;
        if (accept && in_last) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // The final drain cycle is exactly when the last vector reaches the deepest row.
        if (cnt_q == CNT_LAST) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .DEPTH  (r + 1),
      .DATA_W (DATA_W)
    ) u_line (
      .clk        (clk),
      .rst        (rst),
      .push_valid (accept),
      .push_data  (in_data[r]),
      .valid      (act_valid[r]),
      .data       (act_out[r])
    );
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder (ROWS=4, DATA_W=16) with a per-cycle diagonal scoreboard.
module tb_act_skew_feeder;

  localparam int ROWS   = 4;
  localparam int DATA_W = 16;

  typedef logic [ROWS-1:0][DATA_W-1:0] vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  vec_t        in_data;
  logic        in_last;
  vec_t        act_out;
  logic [ROWS-1:0] act_valid;
  logic        busy;
  logic        done;

  act_skew_feeder #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .act_out   (act_out),
    .act_valid (act_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cnum     = 0;

  // Scoreboard: entry r holds what row r must present in the current cycle.
  logic              hist_v [ROWS];
  logic [DATA_W-1:0] hist_d [ROWS];
  int drain_left = 0;
  logic in_tile = 1'b0;
  int lasts_expected = 0;
  int done_seen = 0;

  vec_t v_single, v0, v1, v2, w0, va, vb, vx, vy, vz, junk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) begin
      hist_v[r] = 1'b0;
      hist_d[r] = '0;
    end
    if (drain_left != 0) lasts_expected--;
    drain_left = 0;
    in_tile = 1'b0;
  endtask

  task automatic scoreboard_check();
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("sb_valid_r%0d_c%0d", r, cnum), {31'd0, act_valid[r]}, {31'd0, hist_v[r]});
      chk($sformatf("sb_data_r%0d_c%0d", r, cnum), {16'd0, act_out[r]}, {16'd0, hist_d[r]});
    end
    chk($sformatf("sb_ready_c%0d", cnum), {31'd0, in_ready}, {31'd0, (drain_left == 0)});
    chk($sformatf("sb_done_c%0d", cnum), {31'd0, done}, {31'd0, (drain_left == 1)});
    chk($sformatf("sb_busy_c%0d", cnum), {31'd0, busy}, {31'd0, (in_tile || drain_left != 0)});
    if (done === 1'b1) done_seen++;
  endtask

  // One cycle: drive inputs, check mid-cycle, advance the model at the posedge.
  task automatic cyc(input logic v, input vec_t d, input logic l);
    logic acc;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    scoreboard_check();
    acc = v && (drain_left == 0);
    @(posedge clk);
    for (int r = ROWS - 1; r > 0; r--) begin
      hist_v[r] = hist_v[r-1];
      hist_d[r] = hist_d[r-1];
    end
    hist_v[0] = acc;
    hist_d[0] = acc ? d[0] : '0;
    for (int r = ROWS - 1; r > 0; r--) hist_d[r] = hist_d[r];
    if (drain_left != 0) begin
      drain_left--;
      if (drain_left == 0) in_tile = 1'b0;
    end else if (acc) begin
      in_tile = 1'b1;
      if (l) begin
        drain_left = ROWS;
        lasts_expected++;
      end
    end
    cnum++;
    #1;
  endtask

  // Row r is fed from element r of the vector, so the history carries each row's own lane.
  vec_t hist_vec [ROWS];
  task automatic fix_lanes(input logic acc, input vec_t d);
    for (int r = ROWS - 1; r > 0; r--) hist_vec[r] = hist_vec[r-1];
    hist_vec[0] = acc ? d : '0;
    for (int r = 0; r < ROWS; r++) hist_d[r] = hist_v[r] ? hist_vec[r][r] : '0;
  endtask

  task automatic step(input logic v, input vec_t d, input logic l);
    logic acc;
    acc = v && (drain_left == 0);
    cyc(v, d, l);
    fix_lanes(acc, d);
  endtask

  task automatic idle_to(input int n);
    while (cnum < n) step(1'b0, junk, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_valid", {28'd0, act_valid}, 32'd0);
      chk("rst_hold_done", {31'd0, done}, 32'd0);
      chk("rst_hold_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0;
    model_clear();
    for (int r = 0; r < ROWS; r++) hist_vec[r] = '0;
    cnum = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, {28'd0, act_valid}, 32'd0);
    chk({tag, "_out"}, {act_out[3], act_out[2]} | {act_out[1], act_out[0]}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cnum);
    $fatal(1, "watchdog");
  end

  initial begin
    v_single = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    v0   = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    v1   = {16'h1113, 16'h1112, 16'h1111, 16'h1110};
    v2   = {16'h2223, 16'h2222, 16'h2221, 16'h2220};
    w0   = {16'h5553, 16'h5552, 16'h5551, 16'h5550};
    va   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    vb   = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    vx   = {16'h7003, 16'h7002, 16'h7001, 16'h7000};
    vy   = {16'h7103, 16'h7102, 16'h7101, 16'h7100};
    vz   = {16'h7203, 16'h7202, 16'h7201, 16'h7200};
    junk = {16'hDEAD, 16'hBEEF, 16'hFFFF, 16'h1234};
    for (int r = 0; r < ROWS; r++) hist_vec[r] = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;

    // Power-on reset.
    do_reset(2);
    check_quiet("por");

    // Single-vector tile accepted in cycle 10.
    idle_to(10);
    step(1'b1, v_single, 1'b1);
    for (int i = 0; i < ROWS; i++) begin
      chk($sformatf("single_valid_c%0d", cnum), {28'd0, act_valid}, 32'd1 << i);
      chk($sformatf("single_out_c%0d", cnum), {16'd0, act_out[i]}, {16'd0, v_single[i]});
      chk($sformatf("single_ready_c%0d", cnum), {31'd0, in_ready}, 32'd0);
      chk($sformatf("single_done_c%0d", cnum), {31'd0, done}, (i == ROWS - 1) ? 32'd1 : 32'd0);
      step(1'b0, junk, 1'b0);
    end
    chk("single_ready_c15", {31'd0, in_ready}, 32'd1);
    chk("single_valid_c15", {28'd0, act_valid}, 32'd0);
    chk("single_done_c15", {31'd0, done}, 32'd0);
    idle_to(20);

    // Back-to-back V0..V2, then in_valid held high through DRAIN.
    do_reset(1);
    idle_to(5);
    step(1'b1, v0, 1'b0);
    step(1'b1, v1, 1'b0);
    step(1'b1, v2, 1'b1);
    chk("b2b_row2_c8", {16'd0, act_out[2]}, {16'd0, v0[2]});
    chk("b2b_row2v_c8", {31'd0, act_valid[2]}, 32'd1);
    step(1'b1, junk, 1'b1);
    chk("b2b_row2_c9", {16'd0, act_out[2]}, {16'd0, v1[2]});
    step(1'b1, junk, 1'b0);
    chk("b2b_row2_c10", {16'd0, act_out[2]}, {16'd0, v2[2]});
    chk("b2b_ready_c10", {31'd0, in_ready}, 32'd0);
    step(1'b1, junk, 1'b1);
    chk("b2b_done_c11", {31'd0, done}, 32'd1);
    chk("b2b_row3_c11", {16'd0, act_out[3]}, {16'd0, v2[3]});
    chk("b2b_valid_c11", {28'd0, act_valid}, 32'h8);
    step(1'b1, junk, 1'b0);
    chk("b2b_ready_c12", {31'd0, in_ready}, 32'd1);
    chk("b2b_done_c12", {31'd0, done}, 32'd0);
    step(1'b1, w0, 1'b1);
    chk("next_tile_valid_c13", {28'd0, act_valid}, 32'h1);
    chk("next_tile_out_c13", {16'd0, act_out[0]}, {16'd0, w0[0]});
    idle_to(22);

    // Bubble between two accepts.
    do_reset(1);
    idle_to(5);
    step(1'b1, va, 1'b0);
    step(1'b0, junk, 1'b1);
    step(1'b1, vb, 1'b1);
    step(1'b0, junk, 1'b0);
    chk("bubble_r3v_c9", {31'd0, act_valid[3]}, 32'd1);
    chk("bubble_r3d_c9", {16'd0, act_out[3]}, {16'd0, va[3]});
    step(1'b0, junk, 1'b0);
    chk("bubble_r3v_c10", {31'd0, act_valid[3]}, 32'd0);
    chk("bubble_r3d_c10", {16'd0, act_out[3]}, 32'd0);
    chk("bubble_valid_c10", {28'd0, act_valid}, 32'h4);
    step(1'b0, junk, 1'b0);
    chk("bubble_r3v_c11", {31'd0, act_valid[3]}, 32'd1);
    chk("bubble_r3d_c11", {16'd0, act_out[3]}, {16'd0, vb[3]});
    chk("bubble_done_c11", {31'd0, done}, 32'd1);
    idle_to(16);

    // Reset for two cycles in the middle of a stream.
    do_reset(1);
    idle_to(3);
    step(1'b1, vx, 1'b0);
    step(1'b1, vy, 1'b0);
    do_reset(2);
    check_quiet("rst_stream");
    idle_to(8);

    // Reset in the middle of a drain: the aborted tile must not pulse done.
    step(1'b1, vz, 1'b1);
    step(1'b0, junk, 1'b0);
    do_reset(1);
    check_quiet("rst_drain");
    idle_to(8);

    chk("done_count", done_seen, lasts_expected);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
